// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption round-key source: expands the cipher key one round per cycle, then streams
// round keys 10..0 over valid/ready. Optional replay of the last expansion via AES_KEY_REPLAY_EN.
module aes_inv_key_schedule #(
    parameter int unsigned Nb = 128,
    parameter int unsigned NR = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [Nb-1:0] key_in,
    input  logic          load,
`ifdef AES_KEY_REPLAY_EN
    input  logic          replay,
`endif
    output logic          busy,
    output logic [Nb-1:0] rk_out,
    output logic [3:0]    rk_round,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic          rk_last,
    output logic          done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [3:0] LastRound = 4'(NR);

    logic [1:0]    state_q;
    logic [3:0]    cnt_q;
    logic          done_q;
    logic          have_keys_q;
    logic [Nb-1:0] key_buf [0:NR];

    logic [31:0]   rot_word;
    logic [31:0]   sub_word;
    logic [31:0]   temp;
    logic [31:0]   w0, w1, w2, w3;
    logic [Nb-1:0] prev_key;
    logic [Nb-1:0] next_key;
    logic          replay_go;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (product of x^2..x^128), then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign prev_key = key_buf[cnt_q - 4'd1];
    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign sub_word[8*g +: 8] = sbox(rot_word[8*g +: 8]);
    end

    assign temp     = sub_word ^ {rcon(cnt_q), 24'h000000};
    assign w0       = prev_key[127:96] ^ temp;
    assign w1       = prev_key[95:64] ^ w0;
    assign w2       = prev_key[63:32] ^ w1;
    assign w3       = prev_key[31:0] ^ w2;
    assign next_key = {w0, w1, w2, w3};

`ifdef AES_KEY_REPLAY_EN
    assign replay_go = replay && have_keys_q;
`else
    assign replay_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            done_q      <= 1'b0;
            have_keys_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= EXPAND;
                        cnt_q   <= 4'd1;
                    end else if (replay_go) begin
                        state_q <= STREAM;
                        cnt_q   <= LastRound;
                    end
                end
                EXPAND: begin
                    // cnt_q stays at the last round so the stream starts from it
                    if (cnt_q == LastRound) begin
                        state_q     <= STREAM;
                        have_keys_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                STREAM: begin
                    if (rk_ready) begin
                        if (cnt_q == 4'd0) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && load) begin
            key_buf[0] <= key_in;
        end else if (state_q == EXPAND) begin
            key_buf[cnt_q] <= next_key;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rk_valid = (state_q == STREAM);
    assign rk_out   = rk_valid ? key_buf[cnt_q] : '0;
    assign rk_round = rk_valid ? cnt_q : 4'd0;
    assign rk_last  = rk_valid && (cnt_q == 4'd0);
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Scoreboard bench for aes_inv_key_schedule: a word-level FIPS-197 key expansion model fills the
// expected queue; a negedge monitor checks every transfer, backpressure hold and the done pulse.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         load = 1'b0;
    logic         rk_ready = 1'b0;
    logic         busy;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_last;
    logic         done;
`ifdef AES_KEY_REPLAY_EN
    logic         replay = 1'b0;
`endif

    aes_inv_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .load     (load),
`ifdef AES_KEY_REPLAY_EN
        .replay   (replay),
`endif
        .busy     (busy),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_last  (rk_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int xfer_count = 0;
    bit ready_rand = 1'b0;

    logic [127:0] exp_key[$];
    int           exp_round[$];
    logic [127:0] got_key [0:15];
    logic [7:0]   sbox_t [0:255];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // S-box by brute-force inverse search and the bitwise affine formula.
    task automatic build_sbox();
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    task automatic push_expected(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 10; r >= 0; r--) begin
            exp_key.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
            exp_round.push_back(r);
        end
    endtask

    always @(posedge clk) begin
        #1;
        rk_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [127:0] prev_out;
    logic [3:0]   prev_round;
    bit           prev_stall = 1'b0;
    bit           prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_last  = 1'b0;
        end else begin
            if (prev_stall && rk_valid) begin
                check("hold_out", rk_out, prev_out);
                check("hold_round", 128'(rk_round), 128'(prev_round));
            end
            if (prev_last) begin
                check("done_pulse", 128'(done), 128'(1));
                check("valid_drop", 128'(rk_valid), 128'(0));
            end else begin
                check("no_done", 128'(done), 128'(0));
            end
            if (rk_valid) check("last_flag", 128'(rk_last), 128'(rk_round == 4'd0));
            else check("idle_out_zero", {rk_out, rk_round, rk_last}, 128'(0));
            if (rk_valid && rk_ready) begin
                if (exp_key.size() == 0) begin
                    check("unexpected_xfer", 128'(rk_round), 128'(15));
                end else begin
                    check("rk_round", 128'(rk_round), 128'(exp_round.pop_front()));
                    check("rk_out", rk_out, exp_key.pop_front());
                end
                got_key[rk_round] = rk_out;
                xfer_count++;
            end
            prev_stall = rk_valid && !rk_ready;
            prev_last  = rk_valid && rk_ready && rk_last;
            prev_out   = rk_out;
            prev_round = rk_round;
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!done && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        load = 1'b0;
        check("done_seen", 128'(done), 128'(1));
        check("idle_after_done", 128'(busy), 128'(0));
        check("queue_drained", 128'(exp_key.size()), 128'(0));
        check("xfer_count", 128'(xfer_count), 128'(11));
        @(posedge clk); #1;
    endtask

    // disturb: 1 = stray load during EXPAND, 2 = load held through STREAM incl. final transfer
    task automatic run_key(input logic [127:0] key, input int disturb);
        int n = 0;
        xfer_count = 0;
        push_expected(key);
        key_in = key;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        key_in = ~key;
        while (!rk_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (disturb == 1) load = (n == 3);
        end
        check("latency", 128'(n), 128'(10));
        if (disturb == 2) load = 1'b1;
        wait_done();
    endtask

    initial begin
        logic [127:0] k;
        int n;
        build_sbox();
        #1;
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out", rk_out, 128'(0));
        check("rst_round_last_done", 128'({rk_round, rk_last, done}), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef AES_KEY_REPLAY_EN
        replay = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0;
        repeat (2) begin
            check("replay_before_load", 128'({busy, rk_valid}), 128'(0));
            @(posedge clk); #1;
        end
`endif

        k = 128'h000102030405060708090a0b0c0d0e0f;
        run_key(k, 0);
        check("fips_r10", got_key[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("fips_r1", got_key[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check("fips_r0", got_key[0], k);

`ifdef AES_KEY_REPLAY_EN
        xfer_count = 0;
        push_expected(k);
        replay = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0;
        check("replay_valid", 128'(rk_valid), 128'(1));
        wait_done();
`endif

        ready_rand = 1'b1;
        run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        check("std_r10", got_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("std_r1", got_key[1], 128'ha0fafe1788542cb123a339392a6c7605);

        run_key({$urandom, $urandom, $urandom, $urandom}, 1);
        run_key({$urandom, $urandom, $urandom, $urandom}, 2);

        k = {$urandom, $urandom, $urandom, $urandom};
        push_expected(k);
        key_in = k;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        n = 0;
        while (!(rk_valid && rk_round == 4'd5) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_round5", 128'(rk_round), 128'(5));
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid_busy", 128'({rk_valid, busy, rk_last, done}), 128'(0));
        check("abort_out", rk_out, 128'(0));
        check("abort_round", 128'(rk_round), 128'(0));
        exp_key.delete();
        exp_round.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", 128'({busy, rk_valid}), 128'(0));

        for (int i = 0; i < 4; i++) run_key({$urandom, $urandom, $urandom, $urandom}, i % 3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
